// File: rtl/logistic_arbiter.sv
// Round-robin arbiter sharing one logistic activation unit among N neurons.
// Holds each grant for the whole argument/activation[/feedback/delta] transaction.
module logistic_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            train,

    input  logic [N-1:0]    req_argument_valid,
    output logic [N-1:0]    req_argument_ready,
    input  logic [16*N-1:0] req_argument_data,
    output logic [N-1:0]    req_activation_valid,
    output logic [7:0]      req_activation_data,
    input  logic [N-1:0]    req_activation_ready,
    input  logic [N-1:0]    req_feedback_valid,
    output logic [N-1:0]    req_feedback_ready,
    input  logic [16*N-1:0] req_feedback_data,
    output logic [N-1:0]    req_delta_valid,
    output logic [15:0]     req_delta_data,
    input  logic [N-1:0]    req_delta_ready,

    output logic            unit_train,
    output logic            unit_argument_valid,
    output logic [15:0]     unit_argument_data,
    input  logic            unit_argument_ready,
    input  logic            unit_activation_valid,
    input  logic [7:0]      unit_activation_data,
    output logic            unit_activation_ready,
    output logic            unit_feedback_valid,
    output logic [15:0]     unit_feedback_data,
    input  logic            unit_feedback_ready,
    input  logic            unit_delta_valid,
    input  logic [15:0]     unit_delta_data,
    output logic            unit_delta_ready,

    output logic [W-1:0]    grant,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE,
        ARGUMENT,
        ACTIVATION,
        FEEDBACK,
        DELTA
    } state_t;

    state_t         state;
    logic [W-1:0]   pointer;
    logic           train_q;
    logic           found;
    logic [W-1:0]   pick;

    function automatic logic [W-1:0] rr_index(input logic [W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= N) sum = sum - N;
        return W'(sum);
    endfunction

    function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
        return (v == W'(N - 1)) ? '0 : v + W'(1);
    endfunction

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_argument_valid[rr_index(pointer, k)]) begin
                found = 1'b1;
                pick  = rr_index(pointer, k);
            end
        end
    end

    always_comb begin
        req_argument_ready    = '0;
        req_activation_valid  = '0;
        req_feedback_ready    = '0;
        req_delta_valid       = '0;
        unit_argument_valid   = 1'b0;
        unit_argument_data    = '0;
        unit_activation_ready = 1'b0;
        unit_feedback_valid   = 1'b0;
        unit_feedback_data    = '0;
        unit_delta_ready      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant == W'(i)) begin
                unique case (state)
                    ARGUMENT: begin
                        unit_argument_valid   = req_argument_valid[i];
                        unit_argument_data    = req_argument_data[16*i +: 16];
                        req_argument_ready[i] = unit_argument_ready;
                    end
                    ACTIVATION: begin
                        req_activation_valid[i] = unit_activation_valid;
                        unit_activation_ready   = req_activation_ready[i];
                    end
                    FEEDBACK: begin
                        unit_feedback_valid   = req_feedback_valid[i];
                        unit_feedback_data    = req_feedback_data[16*i +: 16];
                        req_feedback_ready[i] = unit_feedback_ready;
                    end
                    DELTA: begin
                        req_delta_valid[i] = unit_delta_valid;
                        unit_delta_ready   = req_delta_ready[i];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_activation_data = unit_activation_data;
    assign req_delta_data      = unit_delta_data;
    assign unit_train          = train_q;
    assign busy                = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            grant   <= '0;
            pointer <= '0;
            train_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (found) begin
                        grant   <= pick;
                        train_q <= train;
                        state   <= ARGUMENT;
                    end
                end
                ARGUMENT: begin
                    if (unit_argument_valid && unit_argument_ready) state <= ACTIVATION;
                end
                ACTIVATION: begin
                    if (unit_activation_valid && unit_activation_ready) begin
                        if (train_q) begin
                            state <= FEEDBACK;
                        end else begin
                            state   <= IDLE;
                            pointer <= wrap_inc(grant);
                        end
                    end
                end
                FEEDBACK: begin
                    if (unit_feedback_valid && unit_feedback_ready) state <= DELTA;
                end
                DELTA: begin
                    if (unit_delta_valid && unit_delta_ready) begin
                        state   <= IDLE;
                        pointer <= wrap_inc(grant);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logistic_arbiter.sv
// Directed bench for logistic_arbiter; the bench itself plays the logistic unit.
module tb_logistic_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic            clock;
    logic            reset;
    logic            train;
    logic [N-1:0]    req_argument_valid;
    logic [N-1:0]    req_argument_ready;
    logic [16*N-1:0] req_argument_data;
    logic [N-1:0]    req_activation_valid;
    logic [7:0]      req_activation_data;
    logic [N-1:0]    req_activation_ready;
    logic [N-1:0]    req_feedback_valid;
    logic [N-1:0]    req_feedback_ready;
    logic [16*N-1:0] req_feedback_data;
    logic [N-1:0]    req_delta_valid;
    logic [15:0]     req_delta_data;
    logic [N-1:0]    req_delta_ready;
    logic            unit_train;
    logic            unit_argument_valid;
    logic [15:0]     unit_argument_data;
    logic            unit_argument_ready;
    logic            unit_activation_valid;
    logic [7:0]      unit_activation_data;
    logic            unit_activation_ready;
    logic            unit_feedback_valid;
    logic [15:0]     unit_feedback_data;
    logic            unit_feedback_ready;
    logic            unit_delta_valid;
    logic [15:0]     unit_delta_data;
    logic            unit_delta_ready;
    logic [W-1:0]    grant;
    logic            busy;

    int checks;
    int errors;

    logistic_arbiter #(.N(N), .W(W)) dut (
        .clock(clock), .reset(reset), .train(train),
        .req_argument_valid(req_argument_valid), .req_argument_ready(req_argument_ready),
        .req_argument_data(req_argument_data),
        .req_activation_valid(req_activation_valid), .req_activation_data(req_activation_data),
        .req_activation_ready(req_activation_ready),
        .req_feedback_valid(req_feedback_valid), .req_feedback_ready(req_feedback_ready),
        .req_feedback_data(req_feedback_data),
        .req_delta_valid(req_delta_valid), .req_delta_data(req_delta_data),
        .req_delta_ready(req_delta_ready),
        .unit_train(unit_train),
        .unit_argument_valid(unit_argument_valid), .unit_argument_data(unit_argument_data),
        .unit_argument_ready(unit_argument_ready),
        .unit_activation_valid(unit_activation_valid), .unit_activation_data(unit_activation_data),
        .unit_activation_ready(unit_activation_ready),
        .unit_feedback_valid(unit_feedback_valid), .unit_feedback_data(unit_feedback_data),
        .unit_feedback_ready(unit_feedback_ready),
        .unit_delta_valid(unit_delta_valid), .unit_delta_data(unit_delta_data),
        .unit_delta_ready(unit_delta_ready),
        .grant(grant), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // A granted requester must keep its argument valid until the handshake.
    assert property (@(posedge clock) disable iff (!reset)
        (unit_argument_valid && !unit_argument_ready) |=> unit_argument_valid)
        else $error("argument valid dropped before handshake");

    typedef struct {
        logic [3:0]  av;
        logic [3:0]  ar;
        logic        uar;
        logic        uav;
        logic        e_busy;
        logic [1:0]  e_grant;
        logic [3:0]  e_arg_rdy;
        logic [3:0]  e_act_v;
        logic        e_u_arg_v;
        logic        e_u_act_rdy;
        logic [15:0] e_u_arg_d;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        train                 = 1'b0;
        req_argument_valid    = '0;
        req_activation_ready  = '0;
        req_feedback_valid    = '0;
        req_delta_ready       = '0;
        unit_argument_ready   = 1'b0;
        unit_activation_valid = 1'b0;
        unit_activation_data  = 8'h00;
        unit_feedback_ready   = 1'b0;
        unit_delta_valid      = 1'b0;
        unit_delta_data       = 16'h0000;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_grant"}, 32'(grant), 32'd0);
        check({name, "_unit_train"}, 32'(unit_train), 32'd0);
        check({name, "_handshakes"}, 32'({req_argument_ready, req_activation_valid, req_feedback_ready,
              req_delta_valid, unit_argument_valid, unit_activation_ready, unit_feedback_valid,
              unit_delta_ready}), 32'd0);
    endtask

    task automatic apply_reset(input string name);
        @(negedge clock);
        reset = 1'b0;
        clear_inputs();
        #1;
        check_quiet(name);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Acts as an always-ready unit and requester until the grant is released.
    task automatic finish_txn(input string name);
        int cyc;
        cyc = 0;
        unit_argument_ready   = 1'b1;
        unit_activation_valid = 1'b1;
        unit_feedback_ready   = 1'b1;
        unit_delta_valid      = 1'b1;
        req_activation_ready  = '1;
        req_feedback_valid    = '1;
        req_delta_ready       = '1;
        while (busy && cyc < 20) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        check({name, "_done"}, 32'(busy), 32'd0);
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear_inputs();
        req_argument_data = {16'hFF00, 16'h0600, 16'h0100, 16'h0000};
        req_feedback_data = {16'h3333, 16'hFE00, 16'h1111, 16'h0000};

        #2;
        check_quiet("por");
        @(negedge clock);
        reset = 1'b1;

        // Single inference from requester 0.
        @(negedge clock);
        req_argument_valid  = 4'b0001;
        unit_argument_ready = 1'b1;
        #1;
        check("t1_idle_busy", 32'(busy), 32'd0);
        @(negedge clock);
        #1;
        check("t1_grant", 32'(grant), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_unit_arg_valid", 32'(unit_argument_valid), 32'd1);
        check("t1_unit_arg_data", 32'(unit_argument_data), 32'h0000);
        check("t1_arg_ready", 32'(req_argument_ready), 32'b0001);
        @(negedge clock);
        req_argument_valid    = '0;
        unit_argument_ready   = 1'b0;
        unit_activation_valid = 1'b1;
        unit_activation_data  = 8'h80;
        req_activation_ready  = 4'b0001;
        #1;
        check("t1_act_valid", 32'(req_activation_valid), 32'b0001);
        check("t1_act_data", 32'(req_activation_data), 32'h80);
        check("t1_unit_act_ready", 32'(unit_activation_ready), 32'd1);
        @(negedge clock);
        clear_inputs();
        #1;
        check("t1_busy_fall", 32'(busy), 32'd0);
        req_argument_valid = 4'b0011;
        @(negedge clock);
        #1;
        check("t1_pointer", 32'(grant), 32'd1);
        finish_txn("t1_next");

        // Round robin with all four requesting, plus back-pressure on requester 1.
        apply_reset("rst2");
        vecs[0]  = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1, 4'h0, 1'b1, 1'b0, 16'h0000};
        vecs[2]  = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 4'h0, 4'h1, 1'b0, 1'b1, 16'h0000};
        vecs[3]  = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 4'h2, 4'h0, 1'b1, 1'b0, 16'h0100};
        for (int i = 5; i < 10; i++)
            vecs[i] = '{4'hF, 4'hD, 1'b1, 1'b1, 1'b1, 2'd1, 4'h0, 4'h2, 1'b0, 1'b0, 16'h0000};
        vecs[10] = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 4'h0, 4'h2, 1'b0, 1'b1, 16'h0000};
        vecs[11] = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 2'd1, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000};
        vecs[12] = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd2, 4'h0, 4'h0, 1'b1, 1'b0, 16'h0600};
        vecs[13] = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd2, 4'h4, 4'h0, 1'b1, 1'b0, 16'h0600};
        vecs[14] = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 2'd2, 4'h0, 4'h0, 1'b0, 1'b1, 16'h0000};
        vecs[15] = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd2, 4'h0, 4'h4, 1'b0, 1'b1, 16'h0000};
        vecs[16] = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 2'd2, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000};
        vecs[17] = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd3, 4'h8, 4'h0, 1'b1, 1'b0, 16'hFF00};
        vecs[18] = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd3, 4'h0, 4'h8, 1'b0, 1'b1, 16'h0000};
        vecs[19] = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 2'd3, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000};
        vecs[20] = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1, 4'h0, 1'b1, 1'b0, 16'h0000};
        vecs[21] = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 4'h0, 4'h1, 1'b0, 1'b1, 16'h0000};
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            req_argument_valid    = vecs[i].av;
            req_activation_ready  = vecs[i].ar;
            unit_argument_ready   = vecs[i].uar;
            unit_activation_valid = vecs[i].uav;
            unit_activation_data  = 8'h80;
            req_feedback_valid    = 4'hF;
            req_delta_ready       = 4'hF;
            unit_feedback_ready   = 1'b1;
            unit_delta_valid      = 1'b1;
            #1;
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
            check($sformatf("v%0d_arg_ready", i), 32'(req_argument_ready), 32'(vecs[i].e_arg_rdy));
            check($sformatf("v%0d_act_valid", i), 32'(req_activation_valid), 32'(vecs[i].e_act_v));
            check($sformatf("v%0d_unit_arg_valid", i), 32'(unit_argument_valid), 32'(vecs[i].e_u_arg_v));
            check($sformatf("v%0d_unit_act_ready", i), 32'(unit_activation_ready), 32'(vecs[i].e_u_act_rdy));
            check($sformatf("v%0d_unit_arg_data", i), 32'(unit_argument_data), 32'(vecs[i].e_u_arg_d));
            check($sformatf("v%0d_train_quiet", i), 32'({req_feedback_ready, req_delta_valid,
                  unit_feedback_valid, unit_delta_ready}), 32'd0);
        end

        // Training transaction on requester 2; train drops during ARGUMENT.
        @(negedge clock);
        clear_inputs();
        req_argument_valid  = 4'b0100;
        train               = 1'b1;
        unit_argument_ready = 1'b1;
        #1;
        check("t3_idle_busy", 32'(busy), 32'd0);
        @(negedge clock);
        train = 1'b0;
        #1;
        check("t3_grant", 32'(grant), 32'd2);
        check("t3_unit_train", 32'(unit_train), 32'd1);
        check("t3_unit_arg_data", 32'(unit_argument_data), 32'h0600);
        check("t3_arg_ready", 32'(req_argument_ready), 32'b0100);
        @(negedge clock);
        req_argument_valid    = '0;
        unit_argument_ready   = 1'b0;
        unit_activation_valid = 1'b1;
        unit_activation_data  = 8'hFF;
        req_activation_ready  = 4'b0100;
        #1;
        check("t3_act_valid", 32'(req_activation_valid), 32'b0100);
        check("t3_act_data", 32'(req_activation_data), 32'hFF);
        @(negedge clock);
        unit_activation_valid = 1'b0;
        req_activation_ready  = '0;
        req_feedback_valid    = 4'b0100;
        unit_feedback_ready   = 1'b1;
        #1;
        check("t3_unit_fb_valid", 32'(unit_feedback_valid), 32'd1);
        check("t3_unit_fb_data", 32'(unit_feedback_data), 32'hFE00);
        check("t3_fb_ready", 32'(req_feedback_ready), 32'b0100);
        check("t3_fb_busy", 32'(busy), 32'd1);
        @(negedge clock);
        req_feedback_valid  = '0;
        unit_feedback_ready = 1'b0;
        unit_delta_valid    = 1'b1;
        unit_delta_data     = 16'h0000;
        req_delta_ready     = 4'b0100;
        #1;
        check("t3_delta_valid", 32'(req_delta_valid), 32'b0100);
        check("t3_unit_delta_ready", 32'(unit_delta_ready), 32'd1);
        check("t3_delta_data", 32'(req_delta_data), 32'h0000);
        @(negedge clock);
        clear_inputs();
        #1;
        check("t3_busy_fall", 32'(busy), 32'd0);
        req_argument_valid = 4'hF;
        @(negedge clock);
        #1;
        check("t3_pointer", 32'(grant), 32'd3);
        finish_txn("t3_next");

        // Move the pointer to 1 so reset's effect on it is visible.
        req_argument_valid = 4'b0001;
        @(negedge clock);
        #1;
        check("t6_setup_grant", 32'(grant), 32'd0);
        finish_txn("t6_setup");

        // Reset asserted while FEEDBACK is stalled.
        req_argument_valid  = 4'b0100;
        train               = 1'b1;
        unit_argument_ready = 1'b1;
        @(negedge clock);
        train = 1'b0;
        #1;
        check("t6_grant", 32'(grant), 32'd2);
        @(negedge clock);
        req_argument_valid    = '0;
        unit_argument_ready   = 1'b0;
        unit_activation_valid = 1'b1;
        req_activation_ready  = 4'b0100;
        @(negedge clock);
        unit_activation_valid = 1'b0;
        req_activation_ready  = '0;
        req_feedback_valid    = 4'b0100;
        #1;
        check("t6_in_feedback", 32'(unit_feedback_valid), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_quiet("t6_reset");
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        req_argument_valid = 4'hF;
        @(negedge clock);
        #1;
        check("t6_first_after_reset", 32'(grant), 32'd0);
        finish_txn("t6_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
